melody_player: RTL and testbench

- Sequencer directly upstream of SoundGenerator.
- Walks a note table in external synchronous-read memory and issues one Start pulse per note with duration and half-period.
- Waits for the generator's Done, optionally inserts a silent inter-note gap, then fetches the next entry.
- Stops on an end marker, or loops back to the start address.

---
 rtl/melody_pkg.sv | 31 +++
 rtl/melody_player.sv | 135 +++++++++++++
 tb/tb_melody_player.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared types and note-table entry layout for the melody sequencer.
// An entry packs the duration in ms above the half-period in us.
package melody_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_NOTE = 3'd4,
    ST_GAP_START = 3'd5,
    ST_WAIT_GAP  = 3'd6
  } state_t;

  localparam int DUR_MSB = 31;
  localparam int DUR_LSB = 16;
  localparam int HP_MSB  = 15;
  localparam int HP_LSB  = 0;

  localparam logic [15:0] END_MARK_DURATION = 16'd0;
  localparam logic [15:0] REST_HALF_PERIOD  = 16'd0;

  function automatic logic [15:0] entry_duration(input logic [31:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

  function automatic logic [15:0] entry_half_period(input logic [31:0] entry);
    return entry[HP_MSB:HP_LSB];
  endfunction

endpackage

// File: rtl/melody_player.sv
// Note-table sequencer: fetches entries, starts the sound generator per note,
// optionally inserts a silent gap, and stops on an end marker or loops.
module melody_player
  import melody_pkg::*;
#(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int ADDR_W   = 8,
  parameter int GAP_MS   = 20
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Play_i,
  input  logic              Stop_i,
  input  logic              Loop_i,
  input  logic [ADDR_W-1:0] StartAddress_i,
  output logic [ADDR_W-1:0] MemAddress_o,
  input  logic [31:0]       MemData_i,
  output logic              GenStart_o,
  output logic              GenFinish_o,
  output logic [15:0]       GenDuration_ms_o,
  output logic [15:0]       GenHalfPeriod_us_o,
  input  logic              GenDone_i,
  output logic              Busy_o,
  output logic              Done_o
);

  // A zero clock rate is not a meaningful configuration; CLOCK_HZ is otherwise informational.
  localparam logic        GAP_EN       = (GAP_MS != 0) && (CLOCK_HZ > 0);
  localparam logic [15:0] GAP_DURATION = 16'(GAP_MS);

  state_t              state_r;
  logic [ADDR_W-1:0]   mem_address_r;
  logic [ADDR_W-1:0]   start_address_r;
  logic                played_any_r;
  logic                gen_start_r;
  logic                gen_finish_r;
  logic [15:0]         gen_duration_r;
  logic [15:0]         gen_half_period_r;
  logic                done_r;
  logic [15:0]         entry_dur_s;
  logic [15:0]         entry_hp_s;

  assign entry_dur_s = entry_duration(MemData_i);
  assign entry_hp_s  = entry_half_period(MemData_i);

  // Sequencer state machine with registered generator/memory outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r           <= ST_IDLE;
      mem_address_r     <= '0;
      start_address_r   <= '0;
      played_any_r      <= 1'b0;
      gen_start_r       <= 1'b0;
      gen_finish_r      <= 1'b0;
      gen_duration_r    <= 16'd0;
      gen_half_period_r <= 16'd0;
      done_r            <= 1'b0;
    end else begin
      gen_start_r  <= 1'b0;
      gen_finish_r <= 1'b0;
      done_r       <= 1'b0;
      if (Stop_i && (state_r != ST_IDLE)) begin
        gen_finish_r <= 1'b1;
        done_r       <= 1'b1;
        state_r      <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (Play_i && !Stop_i) begin
              mem_address_r   <= StartAddress_i;
              start_address_r <= StartAddress_i;
              played_any_r    <= 1'b0;
              state_r         <= ST_FETCH;
            end
          end
          ST_FETCH: state_r <= ST_DECODE;
          ST_DECODE: begin
            if (entry_dur_s == END_MARK_DURATION) begin
              // Loop only if something was heard, else an empty table would spin forever.
              if (Loop_i && played_any_r) begin
                mem_address_r <= start_address_r;
                played_any_r  <= 1'b0;
                state_r       <= ST_FETCH;
              end else begin
                done_r  <= 1'b1;
                state_r <= ST_IDLE;
              end
            end else begin
              gen_duration_r    <= entry_dur_s;
              gen_half_period_r <= entry_hp_s;
              state_r           <= ST_START;
            end
          end
          ST_START: begin
            gen_start_r  <= 1'b1;
            played_any_r <= 1'b1;
            state_r      <= ST_WAIT_NOTE;
          end
          ST_WAIT_NOTE: begin
            if (GenDone_i) begin
              if (GAP_EN) begin
                state_r <= ST_GAP_START;
              end else begin
                mem_address_r <= mem_address_r + ADDR_W'(1);
                state_r       <= ST_FETCH;
              end
            end
          end
          ST_GAP_START: begin
            gen_duration_r    <= GAP_DURATION;
            gen_half_period_r <= REST_HALF_PERIOD;
            gen_start_r       <= 1'b1;
            state_r           <= ST_WAIT_GAP;
          end
          ST_WAIT_GAP: begin
            if (GenDone_i) begin
              mem_address_r <= mem_address_r + ADDR_W'(1);
              state_r       <= ST_FETCH;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign Busy_o             = (state_r != ST_IDLE);
  assign MemAddress_o       = mem_address_r;
  assign GenStart_o         = gen_start_r;
  assign GenFinish_o        = gen_finish_r;
  assign GenDuration_ms_o   = gen_duration_r;
  assign GenHalfPeriod_us_o = gen_half_period_r;
  assign Done_o             = done_r;

endmodule

// File: tb/tb_melody_player.sv
// Self-checking bench: two players (gap off / 20 ms gap) sharing one note table,
// checked against a table-walking reference model and cycle-latency rules.
module tb_melody_player;

  typedef struct packed {
    logic [15:0] dur;
    logic [15:0] hp;
    logic [7:0]  addr;
  } start_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        play [2];
  logic        stop [2];
  logic        loop_s [2];
  logic [7:0]  start_addr [2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_data [2];
  logic        gen_start [2];
  logic        gen_finish [2];
  logic [15:0] gen_dur [2];
  logic [15:0] gen_hp [2];
  logic        gen_done [2];
  logic        busy [2];
  logic        done [2];

  logic [31:0] mem [256];

  int     errors = 0;
  int     checks = 0;
  start_t obs_q[$];
  start_t exp_q[$];
  int     r_first_start, r_done_idx, r_done_cnt, r_finish_cnt;

  always #5 Clock = ~Clock;

  melody_player #(.CLOCK_HZ(10_000_000), .ADDR_W(8), .GAP_MS(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Play_i(play[0]), .Stop_i(stop[0]), .Loop_i(loop_s[0]),
    .StartAddress_i(start_addr[0]), .MemAddress_o(mem_addr[0]), .MemData_i(mem_data[0]),
    .GenStart_o(gen_start[0]), .GenFinish_o(gen_finish[0]), .GenDuration_ms_o(gen_dur[0]),
    .GenHalfPeriod_us_o(gen_hp[0]), .GenDone_i(gen_done[0]), .Busy_o(busy[0]), .Done_o(done[0])
  );

  melody_player #(.CLOCK_HZ(10_000_000), .ADDR_W(8), .GAP_MS(20)) dut20 (
    .Clock(Clock), .Reset(Reset), .Play_i(play[1]), .Stop_i(stop[1]), .Loop_i(loop_s[1]),
    .StartAddress_i(start_addr[1]), .MemAddress_o(mem_addr[1]), .MemData_i(mem_data[1]),
    .GenStart_o(gen_start[1]), .GenFinish_o(gen_finish[1]), .GenDuration_ms_o(gen_dur[1]),
    .GenHalfPeriod_us_o(gen_hp[1]), .GenDone_i(gen_done[1]), .Busy_o(busy[1]), .Done_o(done[1])
  );

  // Synchronous-read note table, one read port per player.
  always @(posedge Clock) begin
    mem_data[0] <= mem[mem_addr[0]];
    mem_data[1] <= mem[mem_addr[1]];
  end

  function automatic int gap_of(input int sel);
    return (sel == 1) ? 20 : 0;
  endfunction

  // Reference: walk the table from sa, listing every generator start (note, then gap).
  function automatic void build_exp(input logic [7:0] sa, input int gap, input logic lp, input int max_n);
    logic [7:0]  a;
    logic [31:0] e;
    bit          played;
    start_t      s;
    a = sa;
    played = 1'b0;
    exp_q.delete();
    for (int guard = 0; guard < 1000 && exp_q.size() < max_n; guard++) begin
      e = mem[a];
      if (e[31:16] == 16'd0) begin
        if (lp && played) begin
          a = sa;
          played = 1'b0;
        end else begin
          break;
        end
      end else begin
        s.dur = e[31:16]; s.hp = e[15:0]; s.addr = a;
        exp_q.push_back(s);
        played = 1'b1;
        if (gap != 0) begin
          s.dur = 16'(gap); s.hp = 16'd0;
          exp_q.push_back(s);
        end
        a = a + 8'd1;
      end
    end
  endfunction

  // Play from sa, acting as the generator (random Done delay); stops on Done_o or after stop_at starts.
  task automatic run_play(input int sel, input logic [7:0] sa, input logic lp, input int stop_at, input int max_cycles);
    int     cd, gd_idx, exp_d;
    bit     finished;
    start_t s;
    obs_q.delete();
    r_first_start = -1; r_done_idx = -1; r_done_cnt = 0; r_finish_cnt = 0;
    cd = 0; gd_idx = -1; finished = 1'b0;
    @(negedge Clock);
    start_addr[sel] = sa; loop_s[sel] = lp; play[sel] = 1'b1;
    @(posedge Clock);
    for (int idx = 0; idx < max_cycles && !finished; idx++) begin
      @(negedge Clock);
      play[sel] = 1'b0;
      gen_done[sel] = 1'b0;
      if (gen_finish[sel]) r_finish_cnt++;
      if (gen_start[sel]) begin
        s.dur = gen_dur[sel]; s.hp = gen_hp[sel]; s.addr = mem_addr[sel];
        obs_q.push_back(s);
        if (r_first_start < 0) begin
          r_first_start = idx;
        end else if (!lp && gd_idx >= 0) begin
          exp_d = (gap_of(sel) != 0 && (obs_q.size() % 2) == 0) ? 2 : 4;
          checks++;
          if (idx - gd_idx != exp_d) begin
            errors++;
            $display("FAIL start_latency dut%0d: got %0d want %0d cycles", sel, idx - gd_idx, exp_d);
          end
        end
        if (stop_at > 0 && obs_q.size() == stop_at) return;
        cd = $urandom_range(5, 2);
      end
      if (done[sel]) begin
        r_done_cnt++;
        r_done_idx = idx;
        if (gd_idx >= 0) begin
          checks++;
          if (idx - gd_idx != 3) begin
            errors++;
            $display("FAIL done_latency dut%0d: got %0d want 3 cycles", sel, idx - gd_idx);
          end
        end
        finished = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          gen_done[sel] = 1'b1;
          gd_idx = idx;
        end
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d: no Done_o within %0d cycles", sel, max_cycles);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({gen_start[d], gen_finish[d], busy[d], done[d]} !== 4'b0000 ||
          mem_addr[d] !== 8'd0 || gen_dur[d] !== 16'd0 || gen_hp[d] !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got addr=%0h dur=%0h hp=%0h flags=%b want all 0",
                 d, mem_addr[d], gen_dur[d], gen_hp[d], {gen_start[d], gen_finish[d], busy[d], done[d]});
      end
    end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_single_note();
    mem[0] = {16'd200, 16'd1136};
    mem[1] = 32'd0;
    build_exp(8'd0, 0, 1'b0, 100);
    run_play(0, 8'd0, 1'b0, 0, 200);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {16'd200, 16'd1136, 8'd0}) begin
      errors++;
      $display("FAIL single_note: got %0d starts first=%h want 1 start %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 40'h0, exp_q[0]);
    end
    checks++;
    if (r_first_start != 3) begin
      errors++; $display("FAIL play_latency: got %0d want 3", r_first_start);
    end
    checks++;
    if (r_done_cnt != 1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%0d busy=%b want 1 0", r_done_cnt, busy[0]);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] sa;
    sa = 8'($urandom_range(200, 100));
    for (int k = 0; k < 3; k++) mem[sa + 8'(k)] = {16'($urandom_range(300, 1)), 16'($urandom_range(3000, 1))};
    mem[sa + 8'd3] = 32'd0;
    build_exp(sa, 20, 1'b0, 100);
    run_play(1, sa, 1'b0, 0, 300);
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL gap_count: got %0d want 6", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gap_seq[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (r_done_cnt != 1 || r_finish_cnt != 0) begin
      errors++; $display("FAIL gap_done: got done=%0d finish=%0d want 1 0", r_done_cnt, r_finish_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] sa;
    int         n, sel;
    for (int it = 0; it < 8; it++) begin
      sel = it % 2;
      sa = 8'($urandom_range(255, 0));
      n = $urandom_range(6, 1);
      for (int k = 0; k < n; k++)
        mem[sa + 8'(k)] = {16'($urandom_range(400, 1)),
                           ($urandom_range(3, 0) == 0) ? 16'd0 : 16'($urandom_range(5000, 1))};
      mem[sa + 8'(n)] = 32'd0;
      build_exp(sa, gap_of(sel), 1'b0, 100);
      run_play(sel, sa, 1'b0, 0, 500);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_count it%0d: got %0d want %0d", it, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_seq it%0d[%0d]: got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (r_first_start != 3 || r_done_cnt != 1) begin
        errors++;
        $display("FAIL rand_frame it%0d: got first=%0d done=%0d want 3 1", it, r_first_start, r_done_cnt);
      end
    end
  endtask

  task automatic test_loop_stop();
    mem[10] = {16'd120, 16'd500};
    mem[11] = {16'd80, 16'd0};
    mem[12] = 32'd0;
    build_exp(8'd10, 0, 1'b1, 5);
    run_play(0, 8'd10, 1'b1, 5, 400);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL loop_seq[%0d]: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
      end
    end
    stop[0] = 1'b1;
    @(negedge Clock);
    stop[0] = 1'b0;
    checks++;
    if ({gen_finish[0], done[0], busy[0]} !== 3'b110) begin
      errors++; $display("FAIL stop_pulse: got fin/done/busy=%b want 110", {gen_finish[0], done[0], busy[0]});
    end
    gen_done[0] = 1'b1;
    @(negedge Clock);
    gen_done[0] = 1'b0;
    checks++;
    if ({gen_finish[0], done[0], busy[0]} !== 3'b000) begin
      errors++; $display("FAIL stop_one_cycle: got fin/done/busy=%b want 000", {gen_finish[0], done[0], busy[0]});
    end
    repeat (4) begin
      @(negedge Clock);
      checks++;
      if ({gen_start[0], done[0], busy[0]} !== 3'b000) begin
        errors++; $display("FAIL late_done_ignored: got start/done/busy=%b want 000", {gen_start[0], done[0], busy[0]});
      end
    end
    loop_s[0] = 1'b0;
  endtask

  task automatic test_empty_loop();
    for (int d = 0; d < 2; d++) begin
      mem[40] = 32'd0;
      run_play(d, 8'd40, 1'b1, 0, 50);
      checks++;
      if (r_done_idx != 2 || r_done_cnt != 1 || obs_q.size() != 0) begin
        errors++;
        $display("FAIL empty_loop dut%0d: got done_at=%0d done=%0d starts=%0d want 2 1 0",
                 d, r_done_idx, r_done_cnt, obs_q.size());
      end
      loop_s[d] = 1'b0;
    end
  endtask

  task automatic test_wrap();
    mem[255] = {16'd33, 16'd777};
    mem[0]   = 32'd0;
    build_exp(8'd255, 0, 1'b0, 100);
    run_play(0, 8'd255, 1'b0, 0, 200);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL wrap_note: got %0d starts want 1 of %h", obs_q.size(), exp_q[0]);
    end
    checks++;
    if (r_done_cnt != 1 || mem_addr[0] !== 8'd0) begin
      errors++; $display("FAIL wrap_addr: got done=%0d addr=%0d want 1 0", r_done_cnt, mem_addr[0]);
    end
  endtask

  task automatic test_reset_mid();
    mem[50] = {16'd90, 16'd321};
    mem[51] = 32'd0;
    run_play(0, 8'd50, 1'b0, 1, 100);
    Reset = 1'b0;
    #1;
    checks++;
    if ({gen_start[0], gen_finish[0], busy[0], done[0]} !== 4'b0000 ||
        mem_addr[0] !== 8'd0 || gen_dur[0] !== 16'd0 || gen_hp[0] !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: got addr=%0d dur=%0d hp=%0d busy=%b want all 0",
               mem_addr[0], gen_dur[0], gen_hp[0], busy[0]);
    end
    @(negedge Clock);
    Reset = 1'b1;
    gen_done[0] = 1'b1;
    @(negedge Clock);
    gen_done[0] = 1'b0;
    repeat (4) begin
      checks++;
      if ({gen_start[0], gen_finish[0], busy[0], done[0]} !== 4'b0000) begin
        errors++; $display("FAIL reset_mid_quiet: got flags=%b want 0000",
                           {gen_start[0], gen_finish[0], busy[0], done[0]});
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_idle_inputs();
    mem[60] = {16'd10, 16'd10};
    mem[61] = 32'd0;
    @(negedge Clock);
    start_addr[0] = 8'd60;
    stop[0] = 1'b1;
    @(negedge Clock);
    play[0] = 1'b1;
    @(negedge Clock);
    play[0] = 1'b0; stop[0] = 1'b0; gen_done[0] = 1'b1;
    @(negedge Clock);
    gen_done[0] = 1'b0;
    repeat (5) begin
      checks++;
      if ({gen_start[0], gen_finish[0], busy[0], done[0]} !== 4'b0000) begin
        errors++; $display("FAIL idle_inputs: got flags=%b want 0000",
                           {gen_start[0], gen_finish[0], busy[0], done[0]});
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      play[d] = 1'b0; stop[d] = 1'b0; loop_s[d] = 1'b0; start_addr[d] = 8'd0; gen_done[d] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    test_reset();
    test_single_note();
    test_gaps();
    test_random();
    test_loop_stop();
    test_empty_loop();
    test_wrap();
    test_reset_mid();
    test_idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
